// File: rtl/counter_pkg.sv
// Shared types and constants for the counter fabric.
package counter_pkg;

    localparam int DEF_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer; master drives the controls.
interface countdown_timer_if #(
    parameter int WIDTH = counter_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, load_val, en, auto_reload,
        input  count, busy, tc, done
    );

    modport slave (
        input  start, load_val, en, auto_reload,
        output count, busy, tc, done
    );
endinterface

// File: rtl/tff_down_stage.sv
// One bit of a T flip-flop down counter: async clear, sync load, toggle on borrow.
module tff_down_stage (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic d_i,
    input  logic dec_i,
    input  logic lz_i,   // every lower count bit is zero
    output logic q_o
);
    logic q_q;

    // Load wins over toggle; a bit flips on decrement when all lower bits are zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_q <= 1'b0;
        else if (load_i)
            q_q <= d_i;
        else if (dec_i && lz_i)
            q_q <= ~q_q;
    end

    assign q_o = q_q;
endmodule

// File: rtl/countdown_timer.sv
// Loadable, enable-gated down counter with terminal-count pulse and auto-reload.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);
    cnt_state_e       state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] zero_below;
    logic [WIDTH-1:0] load_data;
    logic             load, dec, cnt_zero;

    assign cnt_zero = (cnt == '0);

    // Borrow chain: bit i toggles only when bits below it are all zero.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            if (gi == 0) begin : g_lsb
                assign zero_below[gi] = 1'b1;
            end else begin : g_upper
                assign zero_below[gi] = zero_below[gi-1] & ~cnt[gi-1];
            end
            tff_down_stage u_stage (
                .clk    (clk),
                .reset  (reset),
                .load_i (load),
                .d_i    (load_data[gi]),
                .dec_i  (dec),
                .lz_i   (zero_below[gi]),
                .q_o    (cnt[gi])
            );
        end
    endgenerate

    // State, reload value and terminal-count pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next state plus counter load/decrement controls; start always takes priority.
    always_comb begin
        state_d   = state_q;
        reload_d  = reload_q;
        tc_d      = 1'b0;
        load      = 1'b0;
        load_data = bus.load_val;
        dec       = 1'b0;
        if (bus.start) begin
            // Restart from any state; a terminal count this cycle is dropped.
            load     = 1'b1;
            reload_d = bus.load_val;
            state_d  = RUN;
        end else if (state_q == RUN && bus.en) begin
            if (!cnt_zero) begin
                dec = 1'b1;
            end else begin
                // Zero never wraps to all-ones: it is always a terminal count.
                tc_d = 1'b1;
                if (bus.auto_reload) begin
                    load      = 1'b1;
                    load_data = reload_q;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    // Status outputs decoded from registered state.
    always_comb begin
        bus.busy  = (state_q == RUN);
        bus.done  = (state_q == DONE);
        bus.tc    = tc_q;
        bus.count = cnt;
    end
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;
    import counter_pkg::*;

    localparam int W = 3;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    countdown_timer_if #(.WIDTH(W)) bus ();

    countdown_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int c, input int b, input int t, input int d);
        chk({name, ".count"}, int'(bus.count), c);
        chk({name, ".busy"},  int'(bus.busy),  b);
        chk({name, ".tc"},    int'(bus.tc),    t);
        chk({name, ".done"},  int'(bus.done),  d);
    endtask

    task automatic do_start(input int val);
        bus.start    = 1'b1;
        bus.load_val = W'(val);
        step();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.load_val = '0; bus.en = 1'b1; bus.auto_reload = 1'b0;
        step(); step();
        chk_all("reset", 0, 0, 0, 0);
        #2 reset = 1'b1;
        step();
        chk_all("idle_ignores_en", 0, 0, 0, 0);
    endtask

    task automatic test_single_shot();
        bus.en = 1'b1; bus.auto_reload = 1'b0;
        do_start(5);
        chk_all("ss_load", 5, 1, 0, 0);
        for (int i = 4; i >= 0; i--) begin
            step();
            chk_all("ss_cnt", i, 1, 0, 0);
        end
        step();
        chk_all("ss_tc", 0, 0, 1, 1);
        step();
        chk_all("ss_done", 0, 0, 0, 1);
        step();
        chk_all("ss_hold", 0, 0, 0, 1);
    endtask

    task automatic test_auto_reload();
        int exp_c[12] = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1, 0, 3};
        bus.en = 1'b1; bus.auto_reload = 1'b1;
        do_start(3);
        chk_all("ar_load", 3, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk_all("ar_cyc", exp_c[i], 1, (exp_c[i] == 3) ? 1 : 0, 0);
        end
        bus.auto_reload = 1'b0;
    endtask

    task automatic test_en_gating();
        int exp_c[8] = '{3, 3, 2, 2, 1, 1, 0, 0};
        bus.auto_reload = 1'b0;
        do_start(4);
        chk_all("en_load", 4, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            bus.en = (i % 2 == 0);
            step();
            chk_all("en_cyc", exp_c[i], 1, 0, 0);
        end
        bus.en = 1'b1;
        step();
        chk_all("en_tc9", 0, 0, 1, 1);
    endtask

    task automatic test_restart();
        bus.en = 1'b1; bus.auto_reload = 1'b0;
        do_start(5);
        step(); step(); step();
        chk_all("rs_at2", 2, 1, 0, 0);
        do_start(7);
        chk_all("rs_load7", 7, 1, 0, 0);
        step();
        chk_all("rs_next", 6, 1, 0, 0);
    endtask

    task automatic test_load_zero();
        bus.en = 1'b0; bus.auto_reload = 1'b0;
        do_start(0);
        chk_all("z_load", 0, 1, 0, 0);
        step();
        chk_all("z_paused", 0, 1, 0, 0);
        bus.en = 1'b1;
        step();
        chk_all("z_tc", 0, 0, 1, 1);
    endtask

    task automatic test_load_max();
        bus.en = 1'b1; bus.auto_reload = 1'b0;
        do_start(7);
        chk_all("m_load", 7, 1, 0, 0);
        for (int i = 6; i >= 0; i--) begin
            step();
            chk_all("m_cnt", i, 1, 0, 0);
        end
        step();
        chk_all("m_tc", 0, 0, 1, 1);
        step();
        chk_all("m_nowrap", 0, 0, 0, 1);
    endtask

    task automatic test_async_reset();
        bus.en = 1'b1; bus.auto_reload = 1'b1;
        do_start(5);
        step(); step();
        chk_all("ar_pre", 3, 1, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk_all("ar_async", 0, 0, 0, 0);
        step();
        #3 reset = 1'b1;
        step(); step(); step();
        chk_all("ar_idle", 0, 0, 0, 0);
        bus.auto_reload = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_shot();
        test_auto_reload();
        test_en_gating();
        test_restart();
        test_load_zero();
        test_load_max();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, enable-gated down counter. It counts from a programmed value to zero, flags terminal count, and optionally auto-reloads. It is the count-down counterpart of the 3-bit ripple-style up counter already in the design. It provides the timeout and interval-tick source for the control logic. It is built from T-flip-flop down-count stages so it matches the existing counter fabric.

## Interface

Parameters:
- WIDTH, default 3: counter width in bits; legal range 2–8.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request; samples load_val.
- load_val  in  WIDTH  start value; also latched as the reload value.
- en  in  1  count enable; when low, the counter freezes, including in RUN.
- auto_reload  in  1  when high at terminal count, reload and keep running.
- count  out  WIDTH  current counter value, registered.
- busy  out  1  high in RUN.
- tc  out  1  one-cycle terminal-count pulse, registered.
- done  out  1  high in DONE, until the next start.

## Operation

- States: IDLE, RUN, DONE.
- Reset (reset=0, asynchronous): state=IDLE, count=0, reload register=0, busy=0, tc=0, done=0.
- IDLE
  - start=1: count←load_val, reload←load_val, go to RUN.
  - en is ignored.
- RUN, evaluated each clock edge in priority order:
  1. start=1: count←load_val, reload←load_val, stay in RUN. This restarts the count and suppresses tc this cycle.
  2. en=0: hold count and state.
  3. en=1 and count≠0: count←count−1.
  4. en=1 and count=0: tc←1 next cycle. Then:
     - auto_reload=1: count←reload, stay in RUN.
     - auto_reload=0: go to DONE; count stays 0.
- DONE
  - done=1, count=0.
  - start=1: load and go to RUN, as from IDLE.
  - Otherwise hold.
- Arithmetic: unsigned modulo-2^WIDTH. count=0 in RUN never decrements to all-ones; the terminal-count branch always applies.
- load_val=0: RUN with count=0. The first enabled cycle produces tc.
- tc is low in every cycle except the one following a terminal-count event. tc and done assert in the same cycle when auto_reload=0.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state.

## Timing

- Start latency: start sampled at edge n gives count=load_val and busy=1 after edge n.
- Period with en held high: L+1 enabled edges from load to tc. tc is visible after edge n+L+1.
- Auto-reload period: L+1 enabled cycles between consecutive tc pulses.
- en low pauses the count without losing state. The period stretches by exactly the number of en-low cycles.
- Asynchronous reset during RUN takes effect immediately, without waiting for clk. Outputs go to reset values and any pending tc is lost.
- Reset release is synchronised by the system. The block performs no internal reset synchronisation.

## Structure

- Shared package counter_pkg holds:
  - the state enum type (IDLE, RUN, DONE);
  - the default WIDTH constant, 3.
- Sub-module tff_down_stage: one T flip-flop bit slice with asynchronous active-low clear and synchronous load.
  - Toggle condition: T_i = dec & (all lower count bits == 0).
  - Load has priority over toggle.
  - Instantiate WIDTH copies.
- The FSM and the tc/reload registers live in the top level.

## Test plan

- Reset then start with load_val=5, en=1, auto_reload=0:
  - count goes 5,4,3,2,1,0;
  - tc=1 for exactly one cycle, 6 edges after load;
  - done=1 and busy=0 thereafter;
  - count stays 0.
- load_val=3, auto_reload=1, en=1, run for 12 cycles: tc pulses every 4 cycles, and count cycles 3,2,1,0,3,…
- load_val=4 with en toggling 1,0,1,0…: each value persists for 2 cycles, and tc appears after 9 edges instead of 5.
- While count=2 in RUN, assert start with load_val=7: count=7 next cycle, no tc, busy stays 1.
- start with load_val=0: tc on the first enabled cycle, then DONE. Also drive load_val=7 (max) to check the full range without wrap to all-ones.
- Assert reset low mid-count (count=3) between clock edges: count=0, busy=0, tc=0, done=0 immediately. After release, the block is in IDLE and ignores en until start.
